// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encodings and result-select helper for mul_pipe
// Contents:
//   OP_W       width of the op field
//   MAX_W      widest operand width the select helper handles
//   mul_op_e   MUL_LO=00, MUL_HSS=01, MUL_HSU=10, MUL_HUU=11
//   mul_select picks the low or high W-bit word of a 2W-bit product
package mul_pkg;

    localparam int OP_W  = 2;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_e;

    // p carries the 2W-bit product zero-extended to 2*MAX_W bits.
    // The caller keeps only the low W bits of the return value.
    function automatic logic [MAX_W-1:0] mul_select(input logic [2*MAX_W-1:0] p,
                                                    input mul_op_e op,
                                                    input int unsigned w);
        logic [2*MAX_W-1:0] s;
        s = (op == MUL_LO) ? p : (p >> w);
        return s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// rtl/mul_pipe_if.sv - request/result handshake bundle for mul_pipe
// Signals:
//   in_valid/in_ready   request handshake, in_op/in_a/in_b/in_tag request payload
//   out_valid/out_ready result handshake, out_data/out_tag result payload
// Modports: slave = the multiplier, master = the issuing/consuming side
interface mul_pipe_if #(
    parameter int W     = 32,
    parameter int TAG_W = 5
);
    import mul_pkg::*;

    logic             in_valid;
    logic             in_ready;
    mul_op_e          in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/mul_stage.sv
// rtl/mul_stage.sv - one pipeline slice {valid, op, tag, data}
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears everything)
//   en            shift enable; when low the slice holds, bubbles included
//   flush         clears valid at the next edge regardless of en
//   in_*/out_*    slice input and registered output
module mul_stage
    import mul_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  mul_op_e           in_op,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output mul_op_e           out_op,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= MUL_LO;
            out_tag   <= '0;
            out_data  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= in_valid;
            end
            // Payload of a flushed slice is don't-care, so it needs no flush term.
            if (en) begin
                out_op   <= in_op;
                out_tag  <= in_tag;
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - fully pipelined W-bit MUL/MULH/MULHSU/MULHU unit with tag, flush and backpressure
// Parameters: W operand width (8..64), LATENCY accept-to-result cycles (>=1), TAG_W tag width
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       squash every in-flight op; blocks the input in the same cycle
//   busy        any stage holds a valid op
//   bus         mul_pipe_if slave: request in, result out
module mul_pipe
    import mul_pkg::*;
#(
    parameter int W       = 32,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    output logic       busy,
    mul_pipe_if.slave  bus
);

    logic [LATENCY-1:0] v;
    mul_op_e            op_q   [LATENCY];
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [2*W-1:0]     data_q [LATENCY];
    // prod[i] is the product as seen after stage i; stage 0 holds operands instead.
    logic [2*W-1:0]     prod   [LATENCY];

    logic advance;
    logic accept;

    // Global stall: the whole pipe moves only when the last slot can drain.
    assign advance      = !v[LATENCY-1] || bus.out_ready;
    assign bus.in_ready = advance && !flush && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;

    // Operands are sign/zero-extended straight to 2W+2 bits so a plain
    // unsigned multiply truncated to 2W+2 bits equals the signed product.
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sign_a;
    logic             sign_b;
    logic [2*W+1:0]   ext_a;
    logic [2*W+1:0]   ext_b;
    logic [2*W+1:0]   p_full;
    logic             unused_p;

    assign a_q      = data_q[0][2*W-1:W];
    assign b_q      = data_q[0][W-1:0];
    assign sign_a   = (op_q[0] == MUL_HSS || op_q[0] == MUL_HSU) && a_q[W-1];
    assign sign_b   = (op_q[0] == MUL_HSS) && b_q[W-1];
    assign ext_a    = {{(W+2){sign_a}}, a_q};
    assign ext_b    = {{(W+2){sign_b}}, b_q};
    assign p_full   = ext_a * ext_b;
    assign prod[0]  = p_full[2*W-1:0];
    assign unused_p = ^p_full[2*W+1:2*W];

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_first
            mul_stage #(.DATA_W(2*W), .TAG_W(TAG_W)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (advance),
                .flush     (flush),
                .in_valid  (accept),
                .in_op     (bus.in_op),
                .in_tag    (bus.in_tag),
                .in_data   ({bus.in_a, bus.in_b}),
                .out_valid (v[i]),
                .out_op    (op_q[i]),
                .out_tag   (tag_q[i]),
                .out_data  (data_q[i])
            );
        end else begin : g_rest
            mul_stage #(.DATA_W(2*W), .TAG_W(TAG_W)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (advance),
                .flush     (flush),
                .in_valid  (v[i-1]),
                .in_op     (op_q[i-1]),
                .in_tag    (tag_q[i-1]),
                .in_data   (prod[i-1]),
                .out_valid (v[i]),
                .out_op    (op_q[i]),
                .out_tag   (tag_q[i]),
                .out_data  (data_q[i])
            );
            assign prod[i] = data_q[i];
        end
    end

    // The op travels with the product so the word select happens at the output.
    logic [2*MAX_W-1:0] p_wide;
    logic [MAX_W-1:0]   sel;
    logic               unused_sel;

    always_comb begin
        p_wide         = '0;
        p_wide[2*W-1:0] = prod[LATENCY-1];
    end

    assign sel           = mul_select(p_wide, op_q[LATENCY-1], W);
    assign unused_sel    = ^sel;
    assign bus.out_data  = sel[W-1:0];
    assign bus.out_valid = v[LATENCY-1];
    assign bus.out_tag   = tag_q[LATENCY-1];
    assign busy          = |v;

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - self-checking bench for mul_pipe (W32/L3, W16/L1, W32/L4)
module tb_mul_pipe;
    import mul_pkg::*;

    localparam int LAT0 = 3;

    logic clk;
    logic rst_n;
    logic fl0, fl1, fl2;
    logic busy0, busy1, busy2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    exp_t ev [16];
    exp_t q1 [$];
    exp_t q2 [$];

    mul_pipe_if #(.W(32), .TAG_W(5)) b0 ();
    mul_pipe_if #(.W(16), .TAG_W(5)) b1 ();
    mul_pipe_if #(.W(32), .TAG_W(5)) b2 ();

    mul_pipe #(.W(32), .LATENCY(LAT0), .TAG_W(5)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(fl0), .busy(busy0), .bus(b0));
    mul_pipe #(.W(16), .LATENCY(1), .TAG_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(fl1), .busy(busy1), .bus(b1));
    mul_pipe #(.W(32), .LATENCY(4), .TAG_W(5)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(fl2), .busy(busy2), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mathematical reference: interpret operands as signed/unsigned integers,
    // multiply exactly, then take the requested w-bit word.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input int w);
        logic signed [127:0] sa, sb, p, m, two_w;
        two_w = 128'sd1 <<< w;
        m  = two_w - 128'sd1;
        sa = $signed({96'd0, a}) & m;
        sb = $signed({96'd0, b}) & m;
        if ((op == 2'b01 || op == 2'b10) && a[w-1]) sa = sa - two_w;
        if (op == 2'b01 && b[w-1]) sb = sb - two_w;
        p = sa * sb;
        if (op == 2'b00) p = p & m;
        else             p = (p >>> w) & m;
        return p[31:0];
    endfunction

    task automatic idle_all();
        b0.in_valid = 0; b0.in_op = MUL_LO; b0.in_a = '0; b0.in_b = '0; b0.in_tag = '0; b0.out_ready = 0;
        b1.in_valid = 0; b1.in_op = MUL_LO; b1.in_a = '0; b1.in_b = '0; b1.in_tag = '0; b1.out_ready = 0;
        b2.in_valid = 0; b2.in_op = MUL_LO; b2.in_a = '0; b2.in_b = '0; b2.in_tag = '0; b2.out_ready = 0;
        fl0 = 0; fl1 = 0; fl2 = 0;
    endtask

    // Present a random op on u0 and return what it should produce.
    task automatic drive0(input logic [4:0] tag, output exp_t e);
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        b0.in_valid = 1;
        b0.in_op    = mul_op_e'(op);
        b0.in_a     = $urandom;
        b0.in_b     = $urandom;
        b0.in_tag   = tag;
        e.d = ref_mul(b0.in_a, b0.in_b, op, 32);
        e.t = tag;
    endtask

    task automatic test_reset();
        exp_t e;
        logic bad;
        rst_n = 0;
        b0.in_valid = 1;
        b0.out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        n_assert++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", b0.in_ready); end
        n_assert++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", b0.out_valid); end
        n_assert++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_assert++; if (b0.out_data !== 32'h0 || b0.out_tag !== 5'h0) begin n_fail++; $display("FAIL reset_payload: got %h/%h expected 0/0", b0.out_data, b0.out_tag); end
        @(negedge clk);
        rst_n = 1;
        b0.in_valid = 0;
        #1;
        n_assert++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", b0.in_ready); end
        // Reset in the middle of an op must discard it.
        @(negedge clk);
        drive0(5'd7, e);
        @(negedge clk);
        b0.in_valid = 0;
        rst_n = 0;
        #1;
        n_assert++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy: got %b expected 0", busy0); end
        @(negedge clk);
        rst_n = 1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (b0.out_valid) bad = 1;
        end
        n_assert++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midop_reset_result: got out_valid %b expected 0", bad); end
    endtask

    task automatic test_ops();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vx [8];
        logic [1:0]  vo [8];
        logic got;
        va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        vb = '{32'h2, 32'h2, 32'h2, 32'h2,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        vo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
        vx = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
               32'h40000000, 32'h40000000, 32'h00000000, 32'hC0000000};
        b0.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b0.in_valid = 1;
            b0.in_op    = mul_op_e'(vo[i]);
            b0.in_a     = va[i];
            b0.in_b     = vb[i];
            b0.in_tag   = 5'(i);
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                b0.in_valid = 0;
                #1;
                if (b0.out_valid) got = 1;
            end
            n_assert++;
            if (!got) begin
                n_fail++; $display("FAIL op%0d_timeout: got no out_valid expected result", i);
            end else begin
                if (b0.out_data !== vx[i]) begin n_fail++; $display("FAIL op%0d_data: got %h expected %h", i, b0.out_data, vx[i]); end
                n_assert++;
                if (b0.out_tag !== 5'(i)) begin n_fail++; $display("FAIL op%0d_tag: got %0d expected %0d", i, b0.out_tag, i); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        b0.out_ready = 1;
        for (int c = 0; c < 10 + LAT0 + 4; c++) begin
            @(negedge clk);
            if (c < 10) drive0(5'(c), ev[c]);
            else b0.in_valid = 0;
            #1;
            if (c < 10) begin
                n_assert++;
                if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c%0d: got %b expected 1", c, b0.in_ready); end
            end
            if (b0.out_valid) begin
                n_assert++;
                if (cnt >= 10) begin
                    n_fail++; $display("FAIL stream_extra: got result %0d expected only 10", cnt);
                end else begin
                    if (c != cnt + LAT0) begin n_fail++; $display("FAIL stream_latency%0d: got cycle %0d expected %0d", cnt, c, cnt + LAT0); end
                    n_assert++;
                    if (b0.out_data !== ev[cnt].d || b0.out_tag !== ev[cnt].t) begin
                        n_fail++; $display("FAIL stream_result%0d: got %h/%0d expected %h/%0d", cnt, b0.out_data, b0.out_tag, ev[cnt].d, ev[cnt].t);
                    end
                end
                cnt++;
            end
        end
        n_assert++; if (cnt != 10) begin n_fail++; $display("FAIL stream_count: got %0d expected 10", cnt); end
    endtask

    task automatic test_backpressure();
        int nacc, got;
        exp_t e;
        nacc = 0;
        b0.out_ready = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive0(5'(c), e);
            #1;
            if (b0.in_ready) begin ev[nacc] = e; nacc++; end
            if (c >= LAT0) begin
                n_assert++;
                if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL bp_full c%0d: got in_ready %b out_valid %b expected 0 1", c, b0.in_ready, b0.out_valid);
                end
                n_assert++;
                if (b0.out_data !== ev[0].d || b0.out_tag !== ev[0].t) begin
                    n_fail++; $display("FAIL bp_stable c%0d: got %h/%0d expected %h/%0d", c, b0.out_data, b0.out_tag, ev[0].d, ev[0].t);
                end
            end
        end
        n_assert++; if (nacc != LAT0) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", nacc, LAT0); end
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            b0.in_valid  = 0;
            b0.out_ready = 1;
            #1;
            if (b0.out_valid) begin
                n_assert++;
                if (got >= nacc || b0.out_data !== ev[got].d || b0.out_tag !== ev[got].t) begin
                    n_fail++; $display("FAIL bp_drain%0d: got %h/%0d expected %h/%0d", got, b0.out_data, b0.out_tag, ev[got].d, ev[got].t);
                end
                got++;
            end
        end
        n_assert++; if (got != nacc) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got, nacc); end
    endtask

    task automatic test_flush();
        exp_t e;
        logic bad;
        b0.out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive0(5'(c), ev[c]);
        end
        @(negedge clk);
        drive0(5'd31, e);
        fl0 = 1;
        #1;
        n_assert++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", b0.in_ready); end
        n_assert++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== ev[0].d || b0.out_tag !== ev[0].t) begin
            n_fail++; $display("FAIL flush_delivered: got %b %h/%0d expected 1 %h/%0d", b0.out_valid, b0.out_data, b0.out_tag, ev[0].d, ev[0].t);
        end
        @(negedge clk);
        fl0 = 0;
        b0.in_valid = 0;
        #1;
        n_assert++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy0); end
        bad = b0.out_valid;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (b0.out_valid) bad = 1;
        end
        n_assert++; if (bad !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: got out_valid %b expected 0", bad); end
    endtask

    task automatic test_random();
        exp_t e;
        logic [1:0] op;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (cyc < 1485) begin
                op = 2'($urandom_range(0, 3));
                b1.in_valid = ($urandom_range(0, 9) < 7); b1.in_op = mul_op_e'(op);
                b1.in_a = 16'($urandom); b1.in_b = 16'($urandom); b1.in_tag = 5'($urandom);
                b1.out_ready = ($urandom_range(0, 9) < 7); fl1 = ($urandom_range(0, 49) == 0);
                op = 2'($urandom_range(0, 3));
                b2.in_valid = ($urandom_range(0, 9) < 7); b2.in_op = mul_op_e'(op);
                b2.in_a = $urandom; b2.in_b = $urandom; b2.in_tag = 5'($urandom);
                b2.out_ready = ($urandom_range(0, 9) < 7); fl2 = ($urandom_range(0, 49) == 0);
            end else begin
                b1.in_valid = 0; b1.out_ready = 1; fl1 = 0;
                b2.in_valid = 0; b2.out_ready = 1; fl2 = 0;
            end
            #1;
            // W=16, LATENCY=1
            n_assert++;
            if (busy1 !== (q1.size() != 0)) begin n_fail++; $display("FAIL rnd1_busy cyc%0d: got %b expected %b", cyc, busy1, q1.size() != 0); end
            n_assert++;
            if (b1.in_ready !== ((!b1.out_valid || b1.out_ready) && !fl1)) begin
                n_fail++; $display("FAIL rnd1_in_ready cyc%0d: got %b expected %b", cyc, b1.in_ready, (!b1.out_valid || b1.out_ready) && !fl1);
            end
            if (b1.out_valid) begin
                n_assert++;
                if (q1.size() == 0) begin
                    n_fail++; $display("FAIL rnd1_spurious cyc%0d: got %h/%0d expected none", cyc, b1.out_data, b1.out_tag);
                end else begin
                    if (b1.out_data !== q1[0].d[15:0] || b1.out_tag !== q1[0].t) begin
                        n_fail++; $display("FAIL rnd1_result cyc%0d: got %h/%0d expected %h/%0d", cyc, b1.out_data, b1.out_tag, q1[0].d[15:0], q1[0].t);
                    end
                    if (b1.out_ready) void'(q1.pop_front());
                end
            end
            if (fl1) q1.delete();
            if (b1.in_valid && b1.in_ready) begin
                e.d = ref_mul({16'd0, b1.in_a}, {16'd0, b1.in_b}, b1.in_op, 16);
                e.t = b1.in_tag;
                q1.push_back(e);
            end
            // W=32, LATENCY=4
            n_assert++;
            if (busy2 !== (q2.size() != 0)) begin n_fail++; $display("FAIL rnd2_busy cyc%0d: got %b expected %b", cyc, busy2, q2.size() != 0); end
            n_assert++;
            if (b2.in_ready !== ((!b2.out_valid || b2.out_ready) && !fl2)) begin
                n_fail++; $display("FAIL rnd2_in_ready cyc%0d: got %b expected %b", cyc, b2.in_ready, (!b2.out_valid || b2.out_ready) && !fl2);
            end
            if (b2.out_valid) begin
                n_assert++;
                if (q2.size() == 0) begin
                    n_fail++; $display("FAIL rnd2_spurious cyc%0d: got %h/%0d expected none", cyc, b2.out_data, b2.out_tag);
                end else begin
                    if (b2.out_data !== q2[0].d || b2.out_tag !== q2[0].t) begin
                        n_fail++; $display("FAIL rnd2_result cyc%0d: got %h/%0d expected %h/%0d", cyc, b2.out_data, b2.out_tag, q2[0].d, q2[0].t);
                    end
                    if (b2.out_ready) void'(q2.pop_front());
                end
            end
            if (fl2) q2.delete();
            if (b2.in_valid && b2.in_ready) begin
                e.d = ref_mul(b2.in_a, b2.in_b, b2.in_op, 32);
                e.t = b2.in_tag;
                q2.push_back(e);
            end
        end
        n_assert++; if (q1.size() != 0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL rnd1_drain: got %0d pending busy %b expected 0 0", q1.size(), busy1); end
        n_assert++; if (q2.size() != 0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL rnd2_drain: got %0d pending busy %b expected 0 0", q2.size(), busy2); end
    endtask

    initial begin
        idle_all();
        rst_n = 0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
